// File: rtl/y86_pkg.sv
// Shared Y86-64 constants, W-stage bundle and status helpers.
package y86_pkg;

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;
  localparam int         NREG  = 15;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } mem_wb_t;

  localparam mem_wb_t W_BUBBLE = '{
    stat:  STAT_BUB,
    icode: I_NOP,
    val_e: 64'd0,
    val_m: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  function automatic logic is_exc(input logic [2:0] s);
    return (s != STAT_BUB) && (s != STAT_AOK);
  endfunction

  function automatic logic [2:0] map_stat(input logic [2:0] s);
    logic [2:0] r;
    r = s;
    unique case (1'b1)
      (s == STAT_BUB): r = STAT_AOK;
      (s > STAT_INS):  r = STAT_INS;
      default:         r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: two async read ports,
// two write ports with port M taking priority.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int          NREG     = 15,
  parameter logic [63:0] RSP_INIT = 64'h0200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [63:0] rdata_a,
  output logic [63:0] rdata_b,
  input  logic        we_e,
  input  logic [3:0]  waddr_e,
  input  logic [63:0] wdata_e,
  input  logic        we_m,
  input  logic [3:0]  waddr_m,
  input  logic [63:0] wdata_m
);

  logic [63:0] regs [NREG];
  logic        ok_a, ok_b, ok_e, ok_m;

  assign ok_a = (raddr_a != RNONE) && (int'(raddr_a) < NREG);
  assign ok_b = (raddr_b != RNONE) && (int'(raddr_b) < NREG);
  assign ok_e = we_e && (waddr_e != RNONE) &&
                (int'(waddr_e) < NREG);
  assign ok_m = we_m && (waddr_m != RNONE) &&
                (int'(waddr_m) < NREG);

  assign rdata_a = ok_a ? regs[raddr_a] : 64'd0;
  assign rdata_b = ok_b ? regs[raddr_b] : 64'd0;

  // Port M is written last so it wins on a shared id.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (i == int'(RSP)) ? RSP_INIT : 64'd0;
    end else begin
      if (ok_e) regs[waddr_e] <= wdata_e;
      if (ok_m) regs[waddr_m] <= wdata_m;
    end
  end

endmodule

// File: rtl/writeback.sv
// Y86-64 write-back stage: W register, commit,
// halt logic, status mapping and retire counter.
module writeback
#(
  parameter int          NREG     = y86_pkg::NREG,
  parameter logic [63:0] RSP_INIT = 64'h0200,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic [63:0]      m_valE,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       m_dstE,
  input  logic [3:0]       m_dstM,
  input  logic             w_stall,
  input  logic             w_bubble,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [63:0]      rvalA,
  output logic [63:0]      rvalB,
  output logic [2:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [2:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  import y86_pkg::*;

  mem_wb_t w_q, w_d, m_in;
  logic    w_exc, hold, commit;

  assign m_in = '{
    stat:  m_stat,
    icode: m_icode,
    val_e: m_valE,
    val_m: m_valM,
    dst_e: m_dstE,
    dst_m: m_dstM
  };

  // An exception in W freezes it already on the edge that sets halted.
  assign w_exc  = is_exc(w_q.stat);
  assign hold   = halted | w_exc | w_stall;
  assign commit = (w_q.stat == STAT_AOK) & ~halted;

  always_comb begin
    w_d = w_q;
    if (!hold) w_d = w_bubble ? W_BUBBLE : m_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= W_BUBBLE;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      w_q <= w_d;
      if (w_exc) halted <= 1'b1;
      if (commit && !w_stall)
        retired <= retired + CNT_W'(1);
    end
  end

  y86_regfile #(
    .NREG     (NREG),
    .RSP_INIT (RSP_INIT)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (srcA),
    .raddr_b (srcB),
    .rdata_a (rvalA),
    .rdata_b (rvalB),
    .we_e    (commit),
    .waddr_e (w_q.dst_e),
    .wdata_e (w_q.val_e),
    .we_m    (commit),
    .waddr_m (w_q.dst_m),
    .wdata_m (w_q.val_m)
  );

  assign W_stat   = w_q.stat;
  assign W_icode  = w_q.icode;
  assign W_valE   = w_q.val_e;
  assign W_valM   = w_q.val_m;
  assign W_dstE   = w_q.dst_e;
  assign W_dstM   = w_q.dst_m;
  assign cpu_stat = map_stat(w_q.stat);

endmodule

// File: tb/tb_writeback.sv
// Randomized bench for writeback against a
// behavioural model of the Y86-64 W stage.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE, m_valM;
  logic [3:0]  m_dstE, m_dstM;
  logic        w_stall, w_bubble;
  logic [3:0]  srcA, srcB;
  logic [63:0] rvalA, rvalB;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM;
  logic [2:0]  cpu_stat;
  logic        halted;
  logic [63:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  writeback dut (
    .clk(clk), .rst_n(rst_n),
    .m_stat(m_stat), .m_icode(m_icode),
    .m_valE(m_valE), .m_valM(m_valM),
    .m_dstE(m_dstE), .m_dstM(m_dstM),
    .w_stall(w_stall), .w_bubble(w_bubble),
    .srcA(srcA), .srcB(srcB),
    .rvalA(rvalA), .rvalB(rvalB),
    .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM),
    .cpu_stat(cpu_stat), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [63:0] mreg [15];
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic [63:0] e_valE, e_valM;
  logic [3:0]  e_dstE, e_dstM;
  bit          e_halt;
  logic [63:0] e_ret;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
    mreg[4] = 64'h0200;
    e_stat = 3'd0; e_icode = 4'h1;
    e_valE = 64'd0; e_valM = 64'd0;
    e_dstE = 4'hF; e_dstM = 4'hF;
    e_halt = 1'b0; e_ret = 64'd0;
  endtask

  function automatic logic [63:0] mread(input logic [3:0] a);
    return (a < 4'd15) ? mreg[a] : 64'd0;
  endfunction

  function automatic logic [2:0] exp_cpu(input logic [2:0] s);
    if (s == 3'd0) return 3'd1;
    if (s > 3'd4) return 3'd4;
    return s;
  endfunction

  // One clock edge of the architectural behaviour.
  task automatic model_edge();
    bit live, exc, freeze;
    live   = (e_stat == 3'd1) && !e_halt;
    exc    = (e_stat != 3'd0) && (e_stat != 3'd1);
    freeze = e_halt || exc || w_stall;
    if (live) begin
      if (e_dstE < 4'd15) mreg[e_dstE] = e_valE;
      if (e_dstM < 4'd15) mreg[e_dstM] = e_valM;
      if (!w_stall) e_ret = e_ret + 64'd1;
    end
    if (exc) e_halt = 1'b1;
    if (!freeze) begin
      if (w_bubble) begin
        e_stat = 3'd0; e_icode = 4'h1;
        e_valE = 64'd0; e_valM = 64'd0;
        e_dstE = 4'hF; e_dstM = 4'hF;
      end else begin
        e_stat = m_stat; e_icode = m_icode;
        e_valE = m_valE; e_valM = m_valM;
        e_dstE = m_dstE; e_dstM = m_dstM;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".W_stat"}, W_stat, e_stat);
    check({tag, ".W_icode"}, W_icode, e_icode);
    check({tag, ".W_valE"}, W_valE, e_valE);
    check({tag, ".W_valM"}, W_valM, e_valM);
    check({tag, ".W_dstE"}, W_dstE, e_dstE);
    check({tag, ".W_dstM"}, W_dstM, e_dstM);
    check({tag, ".cpu_stat"}, cpu_stat, exp_cpu(e_stat));
    check({tag, ".halted"}, halted, e_halt);
    check({tag, ".retired"}, retired, e_ret);
    check({tag, ".rvalA"}, rvalA, mread(srcA));
    check({tag, ".rvalB"}, rvalB, mread(srcB));
  endtask

  task automatic drive(input logic [2:0] st,
                       input logic [3:0] ic,
                       input logic [63:0] ve,
                       input logic [63:0] vm,
                       input logic [3:0] de,
                       input logic [3:0] dm,
                       input logic stl,
                       input logic bub);
    m_stat = st; m_icode = ic;
    m_valE = ve; m_valM = vm;
    m_dstE = de; m_dstM = dm;
    w_stall = stl; w_bubble = bub;
  endtask

  task automatic idle();
    drive(3'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Called at posedge+1: asserts reset between edges.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    check({tag, ".rst_cpu"}, cpu_stat, 64'd1);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    srcA = 4'hF; srcB = 4'hF;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      srcA = 4'(i);
      srcB = 4'(15 - i);
      #1;
      check("rst_rvalA", rvalA, (i == 4) ? 64'h0200 : 64'd0);
      check("rst_rvalB", rvalB,
            (15 - i == 4) ? 64'h0200 : 64'd0);
    end
    check("rst_cpu_stat", cpu_stat, 64'd1);
    check("rst_halted", halted, 64'd0);
    check("rst_retired", retired, 64'd0);
    check("rst_W_dstE", W_dstE, 64'hF);

    srcA = 4'd3; srcB = 4'd4;
    drive(3'd1, 4'h3, 64'hDEAD, 64'd0, 4'd3, 4'hF, 1'b0, 1'b0);
    step("t2a");
    check("t2_W_valE", W_valE, 64'hDEAD);
    check("t2_old_read", rvalA, 64'd0);
    idle();
    step("t2b");
    check("t2_rvalA", rvalA, 64'hDEAD);
    check("t2_retired", retired, 64'd1);

    drive(3'd1, 4'hB, 64'h208, 64'h55, 4'd4, 4'd4, 1'b0, 1'b0);
    step("t3a");
    idle();
    step("t3b");
    check("t3_popq", rvalB, 64'h55);

    srcA = 4'd5;
    drive(3'd1, 4'h3, 64'h77, 64'd0, 4'd5, 4'hF, 1'b0, 1'b0);
    step("t4a");
    drive(3'd1, 4'h3, 64'h99, 64'd0, 4'd5, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("t4s");
      check("t4_hold_valE", W_valE, 64'h77);
      check("t4_hold_ret", retired, 64'd2);
    end
    idle();
    step("t4b");
    check("t4_reg5", rvalA, 64'h77);
    check("t4_ret", retired, 64'd3);

    drive(3'd1, 4'h3, 64'h11, 64'd0, 4'd6, 4'hF, 1'b0, 1'b1);
    step("t5a");
    check("t5_bub_dstE", W_dstE, 64'hF);
    check("t5_bub_dstM", W_dstM, 64'hF);
    drive(3'd1, 4'h3, 64'h9, 64'd0, 4'd6, 4'hF, 1'b0, 1'b0);
    step("t5b");
    drive(3'd1, 4'h3, 64'h5, 64'd0, 4'd7, 4'hF, 1'b1, 1'b1);
    step("t5c");
    check("t5_sb_hold", W_dstE, 64'd6);
    idle();
    step("t5d");

    srcA = 4'd2;
    drive(3'd3, 4'h5, 64'd0, 64'd7, 4'hF, 4'd2, 1'b0, 1'b0);
    step("t6a");
    check("t6_cpu_adr", cpu_stat, 64'd3);
    drive(3'd1, 4'h3, 64'h99, 64'd0, 4'd2, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("t6h");
      check("t6_halted", halted, 64'd1);
      check("t6_reg2", rvalA, 64'd0);
      check("t6_cpu", cpu_stat, 64'd3);
    end
    async_reset("t6r");
    check("t6_rst_halted", halted, 64'd0);
    idle();
    step("t6z");

    for (int n = 0; n < 600; n++) begin
      int r;
      logic [2:0] st;
      r = $urandom_range(0, 99);
      if (r < 82) st = 3'd1;
      else if (r < 92) st = 3'd0;
      else st = 3'($urandom_range(2, 7));
      drive(st, 4'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 10));
      srcA = 4'($urandom);
      srcB = 4'($urandom);
      step("rnd");
      if (e_halt && $urandom_range(0, 9) == 0)
        async_reset("rnd_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1, "timeout");
  end

endmodule
